data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, sets memory size to 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 0, range 0..15, sets extra access wait states.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 halfword, 10 word, 11 word.
REQ-009 req_sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  32  formatted load data.
REQ-014 resp_err  out  1  misaligned-access flag, qualified by resp_valid.

Function
REQ-015 Accept occurs on a rising edge where req_valid and req_ready are both 1; all req_* fields are captured at that edge.
REQ-016 FSM states: IDLE, WAIT, RESP; req_ready is 1 in IDLE and RESP, 0 in WAIT.
REQ-017 Accept with WAIT_CYCLES=0 goes to RESP; with WAIT_CYCLES>0 goes to WAIT, loading wait counter with WAIT_CYCLES-1.
REQ-018 WAIT decrements the counter each cycle and goes to RESP when the counter is 0.
REQ-019 RESP lasts one cycle with resp_valid=1, then goes to WAIT/RESP on a new accept in that cycle, else IDLE.
REQ-020 Latency: resp_valid is high exactly WAIT_CYCLES+1 cycles after the accept edge; peak throughput is one access per WAIT_CYCLES+1 cycles.
REQ-021 Word index = req_addr[DEPTH_LOG2+1:2]; higher address bits are ignored (address wraps).
REQ-022 Byte order is little-endian: lane k = word bits [8k+7:8k], k = req_addr[1:0].
REQ-023 Stores write only the addressed lanes (byte: 1 lane; half: lanes addr[1]*2..+1; word: all 4).
REQ-024 Stores commit on the accept edge; resp_rdata for a store response is 0.
REQ-025 Loads read the array in the RESP cycle, so a load accepted after a store to the same address returns the stored data.
REQ-026 Load data is the addressed lane(s) shifted to bit 0, then sign- or zero-extended per req_sext; word loads ignore req_sext.
REQ-027 resp_rdata and resp_err hold their values between responses.
REQ-028 The request is ignored while req_ready=0; the master holds it.

Reset
REQ-029 rst=1 forces IDLE, a wait counter of 0, resp_valid=0, resp_rdata=0, and resp_err=0 on the next edge.
REQ-030 rst mid-operation abandons the pending response; a store already committed at accept is not undone.
REQ-031 Array contents are not cleared by reset.
REQ-032 req_ready is 0 while rst=1.

Configuration
REQ-033 Macro DMEM_MISALIGN_CHECK_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 gives a response with resp_err=1 and resp_rdata=0; a misaligned store writes nothing.
REQ-034 Macro DMEM_MISALIGN_CHECK_EN undefined: resp_err is constant 0; half accesses ignore addr[0] and word accesses ignore addr[1:0]; all accesses proceed.

Verification
REQ-035 WAIT_CYCLES=0: SW 0x12345678 @0x10, then LW @0x10 -> resp_valid one cycle after each accept; rdata=0x12345678.
REQ-036 After REQ-035 data: LB sext @0x13 -> 0x00000012; SB 0xF0 @0x11, then LBU @0x11 -> 0x000000F0, and LB @0x11 -> 0xFFFFFFF0.
REQ-037 After REQ-036 data: LH sext @0x12 -> 0x00001234; SH 0x8001 @0x10, then LH sext @0x10 -> 0xFFFF8001, and LHU -> 0x00008001.
REQ-038 WAIT_CYCLES=3, back-to-back valid loads -> req_ready low 3 cycles after each accept; resp_valid exactly 4 cycles after accept; a new accept occurs in the RESP cycle.
REQ-039 DEPTH_LOG2=10: SW 0xAAAA5555 @0x1000, then LW @0x0 -> 0xAAAA5555 (wrap).
REQ-040 With macro: SW @0x12 -> resp_err=1, memory unchanged. Without macro: SW 0xCAFEBABE @0x12, then LW @0x10 -> 0xCAFEBABE. Also check that rst asserted in WAIT yields no resp_valid.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller: byte/half/word loads and stores with programmable wait states.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;

    logic [31:0]             r_mem [DEPTH];

    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_sext;
    logic [1:0]              r_lane;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_req_mis;
    logic [1:0]              w_req_lane;
    logic [DEPTH_LOG2-1:0]   w_req_idx;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata_rep;
    logic                    w_wr_en;

    logic                    w_eff_we;
    logic [1:0]              w_eff_size;
    logic                    w_eff_sext;
    logic [1:0]              w_eff_lane;
    logic [DEPTH_LOG2-1:0]   w_eff_idx;
    logic                    w_eff_err;
    logic [31:0]             w_rd_word;
    logic [31:0]             w_shift;
    logic [31:0]             w_ld_data;
    logic                    w_unused_addr;

    assign req_ready = ~rst & (r_state != ST_WAIT);
    assign w_accept  = req_valid & req_ready;
    assign w_req_idx = req_addr[DEPTH_LOG2+1:2];

    // Address bits above the array size alias onto the same words.
    assign w_unused_addr = ^req_addr[31:DEPTH_LOG2+2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_req_mis = ((req_size == 2'b01) & req_addr[0]) |
                       (req_size[1] & (req_addr[1:0] != 2'b00));
`else
    assign w_req_mis = 1'b0;
`endif

    // Lane of the lowest addressed byte; half/word accesses snap down to their natural boundary.
    always_comb begin
        w_req_lane  = 2'b00;
        w_be        = 4'b1111;
        w_wdata_rep = req_wdata;
        unique case (req_size)
            2'b00: begin
                w_req_lane  = req_addr[1:0];
                w_be        = 4'b0001 << req_addr[1:0];
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_req_lane  = {req_addr[1], 1'b0};
                w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                w_req_lane  = 2'b00;
                w_be        = 4'b1111;
                w_wdata_rep = req_wdata;
            end
        endcase
    end

    assign w_wr_en = w_accept & req_we & ~w_req_mis;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_req_idx][8*k +: 8] <= w_wdata_rep[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = WAIT_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // With zero wait states the response is formed from the request being accepted right now.
    assign w_eff_we   = w_accept ? req_we     : r_we;
    assign w_eff_size = w_accept ? req_size   : r_size;
    assign w_eff_sext = w_accept ? req_sext   : r_sext;
    assign w_eff_lane = w_accept ? w_req_lane : r_lane;
    assign w_eff_idx  = w_accept ? w_req_idx  : r_idx;
    assign w_eff_err  = w_accept ? w_req_mis  : r_err;

    assign w_rd_word = r_mem[w_eff_idx];
    assign w_shift   = w_rd_word >> {w_eff_lane, 3'b000};

    always_comb begin
        w_ld_data = w_shift;
        unique case (w_eff_size)
            2'b00:   w_ld_data = {{24{w_eff_sext & w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_ld_data = {{16{w_eff_sext & w_shift[15]}}, w_shift[15:0]};
            default: w_ld_data = w_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_sext     <= 1'b0;
            r_lane     <= 2'b00;
            r_idx      <= '0;
            r_err      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we   <= req_we;
                r_size <= req_size;
                r_sext <= req_sext;
                r_lane <= w_req_lane;
                r_idx  <= w_req_idx;
                r_err  <= w_req_mis;
            end
            // Response data is latched as RESP is entered and then held until the next one.
            if (w_state_nxt == ST_RESP) begin
                resp_valid <= 1'b1;
                resp_err   <= w_eff_err;
                resp_rdata <= (w_eff_we | w_eff_err) ? 32'd0 : w_ld_data;
            end else begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (0 and 3 wait states) checked every cycle against a byte-level model.
module tb_data_mem_ctrl;

    localparam int unsigned DL2 = 10;
    localparam int          NB  = 4 << DL2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [1:0]        req_valid, req_we, req_sext, req_ready, resp_valid, resp_err;
    logic [1:0][1:0]   req_size;
    logic [1:0][31:0]  req_addr, req_wdata, resp_rdata;

    data_mem_ctrl #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_sext(req_sext[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0])
    );

    data_mem_ctrl #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_sext(req_sext[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1])
    );

    typedef struct { int due; logic [31:0] rdata; logic err; } exp_t;
    typedef struct { logic [31:0] rdata; logic err; int lat; } got_t;

    logic [7:0]  mem_m [2][NB];
    exp_t        pend [2][$];
    got_t        got  [2][$];
    int          acc_hist [2][$];
    int          ecnt = 0;
    int          free_at [2];
    int          last_acc [2];
    int          acc_cnt [2];
    logic [31:0] last_rd [2];
    logic        last_err [2];
    bit          started = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    // Byte-addressed reference: plain little-endian byte array, extension via signed arithmetic.
    function automatic void model_access(input int d, input logic we, input logic [1:0] sz,
                                         input logic sx, input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int     n;
        int     base;
        longint v;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a % 32'(NB));
        rd   = 32'd0;
        err  = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) begin
            err = 1'b1;
            return;
        end
`endif
        base = base - (base % n);
        if (we) begin
            for (int i = 0; i < n; i++) mem_m[d][base+i] = 8'((wd >> (8*i)) & 32'hFF);
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(mem_m[d][base+i]) << (8*i));
            if (sx && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
            rd = 32'(v);
        end
    endfunction

    // Reference timing: accept when predicted ready, respond WAIT+1 cycles later.
    always @(posedge clk) begin
        bit          acc [2];
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        for (int d = 0; d < 2; d++) acc[d] = !rst && req_valid[d] && (ecnt >= free_at[d]);
        ecnt++;
        if (rst) begin
            started = 1'b1;
            for (int d = 0; d < 2; d++) begin
                pend[d].delete();
                free_at[d]  = ecnt;
                last_rd[d]  = 32'd0;
                last_err[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (acc[d]) begin
                    model_access(d, req_we[d], req_size[d], req_sext[d], req_addr[d], req_wdata[d], rd, er);
                    e.due   = ecnt + wait_of(d);
                    e.rdata = rd;
                    e.err   = er;
                    pend[d].push_back(e);
                    free_at[d]  = ecnt + wait_of(d);
                    last_acc[d] = ecnt;
                    acc_cnt[d]++;
                    acc_hist[d].push_back(ecnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        got_t g;
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d req_ready", d), 32'(req_ready[d]), 32'(!rst && ecnt >= free_at[d]));
                if (resp_valid[d] === 1'b1) begin
                    g.rdata = resp_rdata[d];
                    g.err   = resp_err[d];
                    g.lat   = ecnt - last_acc[d] + 1;
                    got[d].push_back(g);
                end
                if (pend[d].size() > 0 && pend[d][0].due == ecnt) begin
                    e = pend[d].pop_front();
                    chk($sformatf("dut%0d resp_valid", d), 32'(resp_valid[d]), 32'd1);
                    chk($sformatf("dut%0d resp_rdata", d), resp_rdata[d], e.rdata);
                    chk($sformatf("dut%0d resp_err", d), 32'(resp_err[d]), 32'(e.err));
                    last_rd[d]  = e.rdata;
                    last_err[d] = e.err;
                end else begin
                    chk($sformatf("dut%0d resp_valid idle", d), 32'(resp_valid[d]), 32'd0);
                    chk($sformatf("dut%0d resp_rdata hold", d), resp_rdata[d], last_rd[d]);
                    chk($sformatf("dut%0d resp_err hold", d), 32'(resp_err[d]), 32'(last_err[d]));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        int c0;
        int k;
        c0 = acc_cnt[d];
        k  = 0;
        req_we[d]    = we;
        req_size[d]  = sz;
        req_sext[d]  = sx;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        do begin
            step();
            k++;
        end while (acc_cnt[d] == c0 && k < 30);
        req_valid[d] = 1'b0;
        if (acc_cnt[d] == c0) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d accept timeout: got none expected accept for addr 0x%08h", d, a);
        end
    endtask

    task automatic expect_resp(input int d, input logic [31:0] rd, input logic er, input int lat,
                               input string nm);
        got_t g;
        int   k;
        k = 0;
        while (got[d].size() == 0 && k < 40) begin
            step();
            k++;
        end
        if (got[d].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s response timeout: got none expected 0x%08h", nm, rd);
        end else begin
            g = got[d].pop_front();
            chk({nm, " rdata"}, g.rdata, rd);
            chk({nm, " err"}, 32'(g.err), 32'(er));
            chk({nm, " latency"}, 32'(g.lat), 32'(lat));
        end
    endtask

    task automatic flush(input int n);
        repeat (n) step();
        for (int d = 0; d < 2; d++) got[d].delete();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          n0;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_sext  = '0;
        req_size  = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int d = 0; d < 2; d++) begin
            free_at[d] = 0; last_acc[d] = 0; acc_cnt[d] = 0;
            last_rd[d] = 32'd0; last_err[d] = 1'b0;
        end
        repeat (3) step();
        rst = 1'b0;

        // Give the first 16 words of each instance known contents.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) drive(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom());
        flush(6);

        drive(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678); expect_resp(0, 32'h0, 1'b0, 1, "SW 0x10");
        drive(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);        expect_resp(0, 32'h12345678, 1'b0, 1, "LW 0x10");
        drive(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);        expect_resp(0, 32'h00000012, 1'b0, 1, "LB 0x13");
        drive(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'hF0);       expect_resp(0, 32'h0, 1'b0, 1, "SB 0x11");
        drive(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);        expect_resp(0, 32'h000000F0, 1'b0, 1, "LBU 0x11");
        drive(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);        expect_resp(0, 32'hFFFFFFF0, 1'b0, 1, "LB 0x11");
        drive(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);        expect_resp(0, 32'h00001234, 1'b0, 1, "LH 0x12");
        drive(0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h8001);     expect_resp(0, 32'h0, 1'b0, 1, "SH 0x10");
        drive(0, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0);        expect_resp(0, 32'hFFFF8001, 1'b0, 1, "LH 0x10");
        drive(0, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0);        expect_resp(0, 32'h00008001, 1'b0, 1, "LHU 0x10");
        drive(0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'hAAAA5555); expect_resp(0, 32'h0, 1'b0, 1, "SW 0x1000");
        drive(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);         expect_resp(0, 32'hAAAA5555, 1'b0, 1, "LW wrap 0x0");
        drive(0, 1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFEBABE);
`ifdef DMEM_MISALIGN_CHECK_EN
        expect_resp(0, 32'h0, 1'b1, 1, "SW misaligned 0x12");
        drive(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);        expect_resp(0, 32'h12348001, 1'b0, 1, "LW after trap");
`else
        expect_resp(0, 32'h0, 1'b0, 1, "SW unaligned 0x12");
        drive(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);        expect_resp(0, 32'hCAFEBABE, 1'b0, 1, "LW 0x10 forced");
`endif

        // Three wait states: back-to-back loads must be accepted every fourth edge.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 2'd2, 1'b0, 32'(i * 4), 32'h11110000 + 32'(i));
            expect_resp(1, 32'h0, 1'b0, 4, "W3 SW");
        end
        n0 = acc_hist[1].size();
        for (int i = 0; i < 4; i++) drive(1, 1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0);
        for (int i = 0; i < 4; i++) expect_resp(1, 32'h11110000 + 32'(i), 1'b0, 4, "W3 LW b2b");
        for (int i = 1; i < 4; i++)
            chk("W3 accept spacing", 32'(acc_hist[1][n0+i] - acc_hist[1][n0+i-1]), 32'd4);

        // Reset while waiting drops the response but keeps memory.
        flush(4);
        drive(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("rst in WAIT responses", 32'(got[1].size()), 32'd0);
        drive(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);         expect_resp(1, 32'h11110001, 1'b0, 4, "LW after rst");
        flush(4);

        // Random traffic confined to words 0..15, with random aliasing high address bits.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 200; i++) begin
                r = $urandom();
                a = {r[31:12], 6'b0, 4'($urandom_range(15)), 2'($urandom_range(3))};
                drive(d, 1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)), a, $urandom());
                if ($urandom_range(3) == 0) repeat ($urandom_range(3)) step();
            end
            flush(8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
